// File: rtl/sd_filter_seq_pkg.sv
// Shared types and defaults for the sigma-delta filter sequencer.
// Holds the FSM state type and the default sample/word geometry.
package sd_filter_seq_pkg;

  localparam int OSR_DEF = 256;
  localparam int DW_DEF  = 16;
  localparam int PW_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } state_t;

  // sfix16_En7 audio sample
  typedef logic signed [DW_DEF-1:0] sample_t;

endpackage

// File: rtl/sd_bit_packer.sv
// Packs the filter bitstream LSB-first into PW-bit words.
// One output slot; a word finding the slot busy is dropped.
module sd_bit_packer
  import sd_filter_seq_pkg::*;
#(
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          flush,
  input  logic          ce,
  input  logic          data_bit,
  input  logic          clear,
  input  logic          ready,
  output logic          valid,
  output logic [PW-1:0] data,
  output logic          overflow
);

  localparam int CW = (PW > 1) ? $clog2(PW) : 1;

  logic [PW-1:0] pack;
  logic [PW-1:0] word;
  logic [CW-1:0] cnt;
  logic          done;

  always_comb begin
    word      = pack;
    word[cnt] = data_bit;
  end

  assign done = ce && (cnt == CW'(PW-1));

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      pack     <= '0;
      cnt      <= '0;
      valid    <= 1'b0;
      data     <= '0;
      overflow <= 1'b0;
    end else begin
      if (ce) begin
        pack <= word;
        cnt  <= done ? '0 : cnt + 1'b1;
      end
      if (flush)
        cnt <= '0;
      if (done && (!valid || ready)) begin
        data  <= word;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      // a same-cycle drop beats the clear
      if (done && valid && !ready)
        overflow <= 1'b1;
      else if (clear)
        overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/sd_filter_seq.sv
// Sequencer feeding a sigma-delta filter: holds each sample OSR
// cycles on filt_in and packs the returned bitstream into words.
module sd_filter_seq
  import sd_filter_seq_pkg::*;
#(
  parameter int OSR = OSR_DEF,
  parameter int DW  = DW_DEF,
  parameter int PW  = PW_DEF
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          enable,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [PW-1:0] m_data,
  output logic          clk_enable,
  output logic [DW-1:0] filt_in,
  input  logic          ce_out,
  input  logic          filt_out,
  input  logic          clear_flags,
  output logic          underrun,
  output logic          overflow,
  output logic          busy
);

  localparam int HW = (OSR > 1) ? $clog2(OSR) : 1;

  state_t        state;
  logic [HW-1:0] cnt;
  logic [DW-1:0] nxt_q;
  logic          full;
  logic          running;
  logic          accept;
  logic          wrap;

  assign running = (state == RUN) || (state == STOP);
  assign s_ready = (state == FILL) || (running && !full);
  assign accept  = s_valid && s_ready;
  assign wrap    = running && (cnt == HW'(OSR-1));

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state      <= IDLE;
      cnt        <= '0;
      nxt_q      <= '0;
      full       <= 1'b0;
      filt_in    <= '0;
      clk_enable <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (clear_flags)
        underrun <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable)
            state <= FILL;
        end
        FILL: begin
          if (!enable) begin
            state <= IDLE;
          end else if (accept) begin
            // first sample goes straight to the filter
            state      <= RUN;
            filt_in    <= s_data;
            cnt        <= '0;
            clk_enable <= 1'b1;
            busy       <= 1'b1;
          end
        end
        RUN, STOP: begin
          cnt <= wrap ? '0 : cnt + 1'b1;
          if (wrap && state == STOP) begin
            state      <= IDLE;
            filt_in    <= '0;
            full       <= 1'b0;
            clk_enable <= 1'b0;
            busy       <= 1'b0;
          end else begin
            if (state == RUN && !enable)
              state <= STOP;
            if (wrap) begin
              filt_in <= full ? nxt_q : '0;
              if (!full)
                underrun <= 1'b1;
            end
            if (accept) begin
              nxt_q <= s_data;
              full  <= 1'b1;
            end else if (wrap) begin
              full <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sd_bit_packer #(
    .PW(PW)
  ) u_packer (
    .clk      (clk),
    .aresetn  (aresetn),
    .flush    (state == IDLE),
    .ce       (ce_out && clk_enable),
    .data_bit (filt_out),
    .clear    (clear_flags),
    .ready    (m_ready),
    .valid    (m_valid),
    .data     (m_data),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_sd_filter_seq.sv
// Randomized bench for sd_filter_seq with a queue-based
// reference model of the sample hold and the word packer.
module tb_sd_filter_seq;

  localparam int OSR = 256;
  localparam int DW  = 16;
  localparam int PW  = 32;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          enable;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [PW-1:0] m_data;
  logic          clk_enable;
  logic [DW-1:0] filt_in;
  logic          ce_out;
  logic          filt_out;
  logic          clear_flags;
  logic          underrun;
  logic          overflow;
  logic          busy;

  sd_filter_seq #(
    .OSR(OSR), .DW(DW), .PW(PW)
  ) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .enable      (enable),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .clk_enable  (clk_enable),
    .filt_in     (filt_in),
    .ce_out      (ce_out),
    .filt_out    (filt_out),
    .clear_flags (clear_flags),
    .underrun    (underrun),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: accepted samples, packed bits, output slot
  logic [DW-1:0] acc_q[$];
  logic [DW-1:0] pre_q[$];
  logic [DW-1:0] nxt;
  int            rc;
  int            supply;
  bit            bits_q[$];
  logic          mv;
  logic          mov;
  logic [PW-1:0] md;

  function automatic void new_nxt();
    if (pre_q.size() > 0) nxt = pre_q.pop_front();
    else nxt = DW'($urandom);
  endfunction

  // hold period p shows the p-th accepted sample, 0 if none yet
  function automatic logic [DW-1:0] exp_filt();
    int p;
    p = rc / OSR;
    return (p < acc_q.size()) ? acc_q[p] : '0;
  endfunction

  function automatic void edge_model();
    logic [PW-1:0] w;
    bit done;
    w = '0;
    done = 1'b0;
    if (s_valid && s_ready) begin
      acc_q.push_back(s_data);
      new_nxt();
    end
    if (clear_flags) mov = 1'b0;
    if (ce_out && clk_enable) begin
      bits_q.push_back(filt_out);
      if (bits_q.size() == PW) begin
        for (int i = 0; i < PW; i++) w[i] = bits_q[i];
        bits_q.delete();
        done = 1'b1;
      end
    end
    if (done && (!mv || m_ready)) begin
      md = w;
      mv = 1'b1;
    end else if (done) begin
      mov = 1'b1;
    end else if (mv && m_ready) begin
      mv = 1'b0;
    end
    if (clk_enable) rc++;
  endfunction

  task automatic step();
    s_valid = (supply == 1) ||
              (supply == 2 && $urandom_range(0, 3) == 0);
    s_data = nxt;
    edge_model();
    @(negedge clk);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    enable = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b0;
    ce_out = 1'b0;
    filt_out = 1'b0;
    clear_flags = 1'b0;
    supply = 0;
    acc_q.delete();
    pre_q.delete();
    bits_q.delete();
    mv = 1'b0;
    mov = 1'b0;
    md = '0;
    rc = 0;
    new_nxt();
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
  endtask

  task automatic start_run();
    int k;
    enable = 1'b1;
    ce_out = 1'b0;
    k = 0;
    while (!clk_enable && k < 10) begin
      step();
      k++;
    end
    checks++;
    if (clk_enable !== 1'b1) begin
      errors++;
      $display("FAIL start_run: clk_enable=%b after %0d cycles, required 1",
               clk_enable, k);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({clk_enable, s_ready, m_valid, underrun, overflow, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: ce=%b rdy=%b mv=%b und=%b ovf=%b busy=%b, required all 0",
               clk_enable, s_ready, m_valid, underrun, overflow, busy);
    end
    checks++;
    if (filt_in !== '0 || m_data !== '0) begin
      errors++;
      $display("FAIL reset_data: filt_in=%h m_data=%h, required 0",
               filt_in, m_data);
    end
    enable = 1'b1;
    step();
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0 || clk_enable !== 1'b0) begin
      errors++;
      $display("FAIL fill_state: s_ready=%b busy=%b ce=%b, required 1 0 0",
               s_ready, busy, clk_enable);
    end
    enable = 1'b0;
    step();
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0 || filt_in !== '0) begin
      errors++;
      $display("FAIL fill_abort: s_ready=%b busy=%b filt_in=%h, required 0 0 0",
               s_ready, busy, filt_in);
    end
  endtask

  task automatic test_hold();
    logic [DW-1:0] e;
    do_reset();
    pre_q.push_back(16'h0100);
    pre_q.push_back(16'h0200);
    new_nxt();
    supply = 1;
    start_run();
    for (int i = 0; i < 6 * OSR; i++) begin
      e = exp_filt();
      checks++;
      if (filt_in !== e || underrun !== 1'b0) begin
        errors++;
        $display("FAIL hold rc=%0d: filt_in=%h und=%b, required %h und=0",
                 rc, filt_in, underrun, e);
      end
      checks++;
      if (m_valid !== mv || overflow !== mov || (mv && m_data !== md)) begin
        errors++;
        $display("FAIL hold_pack: v=%b d=%h o=%b, required v=%b d=%h o=%b",
                 m_valid, m_data, overflow, mv, md, mov);
      end
      supply = (acc_q.size() < 2) ? 1 : 2;
      ce_out = 1'($urandom);
      filt_out = 1'($urandom);
      m_ready = 1'($urandom);
      clear_flags = ($urandom_range(0, 31) == 0);
      step();
    end
    clear_flags = 1'b0;
    ce_out = 1'b0;
  endtask

  task automatic test_underrun();
    logic [DW-1:0] e;
    logic eu;
    int k;
    do_reset();
    pre_q.push_back(16'h7FFF);
    new_nxt();
    supply = 1;
    start_run();
    k = 0;
    while (rc < 3 * OSR + 4 && k < 4 * OSR) begin
      e = exp_filt();
      if (rc < OSR) eu = 1'b0;
      else if (rc == OSR) eu = 1'b1;
      else if (rc < 2 * OSR) eu = 1'b0;
      else eu = 1'b1;
      checks++;
      if (filt_in !== e || underrun !== eu) begin
        errors++;
        $display("FAIL underrun rc=%0d: filt_in=%h und=%b, required %h und=%b",
                 rc, filt_in, underrun, e, eu);
      end
      supply = (acc_q.size() < 1) ? 1 : 0;
      clear_flags = (rc == OSR) || (rc == 3 * OSR - 1);
      step();
      k++;
    end
    clear_flags = 1'b0;
    checks++;
    if (rc < 3 * OSR + 4) begin
      errors++;
      $display("FAIL underrun_timeout: rc=%0d, required %0d", rc, 3 * OSR + 4);
    end
  endtask

  task automatic test_pack();
    logic [PW-1:0] w1;
    bit tgl;
    do_reset();
    supply = 1;
    start_run();
    tgl = 1'b1;
    m_ready = 1'b1;
    ce_out = 1'b1;
    for (int i = 0; i < 3 * PW; i++) begin
      checks++;
      if (m_valid !== mv || (m_valid && m_data !== 32'h5555_5555)) begin
        errors++;
        $display("FAIL alt_word: v=%b d=%h, required v=%b d=55555555",
                 m_valid, m_data, mv);
      end
      filt_out = tgl;
      tgl = ~tgl;
      step();
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h5555_5555) begin
      errors++;
      $display("FAIL alt_last: v=%b d=%h, required 1 55555555", m_valid, m_data);
    end
    ce_out = 1'b0;
    step();
    m_ready = 1'b0;
    ce_out = 1'b1;
    w1 = '0;
    for (int i = 0; i < 2 * PW; i++) begin
      checks++;
      if (m_valid !== mv || overflow !== mov || (mv && m_data !== md)) begin
        errors++;
        $display("FAIL stall_pack: v=%b d=%h o=%b, required v=%b d=%h o=%b",
                 m_valid, m_data, overflow, mv, md, mov);
      end
      filt_out = 1'($urandom);
      step();
      if (i == PW - 1) w1 = md;
    end
    ce_out = 1'b0;
    step();
    checks++;
    if (m_valid !== 1'b1 || m_data !== w1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drop_word: v=%b d=%h o=%b, required 1 %h 1",
               m_valid, m_data, overflow, w1);
    end
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    checks++;
    if (overflow !== 1'b0 || m_valid !== 1'b1) begin
      errors++;
      $display("FAIL clear_ovf: o=%b v=%b, required 0 1", overflow, m_valid);
    end
    ce_out = 1'b1;
    for (int i = 0; i < PW; i++) begin
      filt_out = 1'($urandom);
      m_ready = (bits_q.size() == PW - 1);
      step();
    end
    m_ready = 1'b0;
    ce_out = 1'b0;
    checks++;
    if (overflow !== 1'b0 || m_valid !== 1'b1 || m_data !== md) begin
      errors++;
      $display("FAIL replace_word: o=%b v=%b d=%h, required 0 1 %h",
               overflow, m_valid, m_data, md);
    end
  endtask

  task automatic test_stop();
    logic [DW-1:0] e;
    int k;
    int after;
    do_reset();
    supply = 1;
    start_run();
    m_ready = 1'b0;
    after = 0;
    k = 0;
    while (clk_enable && k < 3 * OSR) begin
      e = exp_filt();
      checks++;
      if (filt_in !== e) begin
        errors++;
        $display("FAIL stop_hold rc=%0d: filt_in=%h, required %h", rc, filt_in, e);
      end
      if (rc > OSR + 10) after++;
      if (rc == OSR + 10) enable = 1'b0;
      ce_out = (rc < PW + 5);
      filt_out = 1'($urandom);
      step();
      k++;
    end
    ce_out = 1'b0;
    checks++;
    if (after !== OSR - 11) begin
      errors++;
      $display("FAIL stop_len: %0d cycles after deassert, required %0d",
               after, OSR - 11);
    end
    checks++;
    if (busy !== 1'b0 || clk_enable !== 1'b0 || s_ready !== 1'b0 || filt_in !== '0) begin
      errors++;
      $display("FAIL stop_idle: busy=%b ce=%b rdy=%b filt_in=%h, required 0 0 0 0",
               busy, clk_enable, s_ready, filt_in);
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== md) begin
      errors++;
      $display("FAIL stop_keep: v=%b d=%h, required 1 %h", m_valid, m_data, md);
    end
    acc_q.delete();
    bits_q.delete();
    rc = 0;
    start_run();
    ce_out = 1'b1;
    for (int i = 0; i < PW + 8; i++) begin
      checks++;
      if (m_valid !== mv || overflow !== mov || (mv && m_data !== md)) begin
        errors++;
        $display("FAIL restart_pack: v=%b d=%h o=%b, required v=%b d=%h o=%b",
                 m_valid, m_data, overflow, mv, md, mov);
      end
      m_ready = (i == 0);
      filt_out = 1'($urandom);
      step();
    end
    ce_out = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    supply = 1;
    start_run();
    ce_out = 1'b1;
    for (int i = 0; i < PW + 8; i++) begin
      filt_out = 1'($urandom);
      step();
    end
    ce_out = 1'b0;
    supply = 0;
    s_valid = 1'b0;
    aresetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({clk_enable, s_ready, m_valid, underrun, overflow, busy} !== 6'b0 ||
        filt_in !== '0 || m_data !== '0) begin
      errors++;
      $display("FAIL mid_reset: ce=%b rdy=%b mv=%b und=%b ovf=%b busy=%b fi=%h md=%h, required 0",
               clk_enable, s_ready, m_valid, underrun, overflow, busy, filt_in, m_data);
    end
    enable = 1'b0;
    aresetn = 1'b1;
    @(negedge clk);
    checks++;
    if (underrun !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: und=%b ovf=%b busy=%b, required 0 0 0",
               underrun, overflow, busy);
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_underrun();
    test_pack();
    test_stop();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
